// File: rtl/mxrv_csr_file.sv
// Machine-mode CSR file for the mxrv core.
// Holds the trap-handling registers, the interrupt enables and the cycle/instret counters.
// Accesses complete in one cycle, and the registered response carries the pre-write value.
module mxrv_csr_file #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     CNT_W    = 64,
    parameter int unsigned     HART_ID  = 0,
    parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_req_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_ack_o,
    output logic            csr_illegal_o,
    input  logic            inst_retire_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            timer_irq_i,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending_o
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // Only MSIE/MTIE/MEIE exist in mie.
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

    logic            st_mie;
    logic            st_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [CNT_W-1:0] mcycle_q;
    logic [CNT_W-1:0] minstret_q;

    logic [XLEN-1:0]   mstatus_val;
    logic [XLEN-1:0]   mip_val;
    logic [2*XLEN-1:0] cycle_ext;
    logic [2*XLEN-1:0] instret_ext;
    logic [2*XLEN-1:0] cycle_wr;
    logic [2*XLEN-1:0] instret_wr;
    logic [CNT_W-1:0]  cycle_next;
    logic [CNT_W-1:0]  instret_next;

    logic [XLEN-1:0] rd_val;
    logic            rd_mapped;
    logic [XLEN-1:0] wr_val;
    logic            req_valid;
    logic            wr_intent;
    logic            read_only;
    logic            event_busy;
    logic            req_illegal;
    logic            do_write;

    // Zero-extending the counters to two words makes the h-halves read 0 when CNT_W equals XLEN.
    assign cycle_ext   = (2*XLEN)'(mcycle_q);
    assign instret_ext = (2*XLEN)'(minstret_q);

    // Build the architectural views of mstatus (MPP pinned to M-mode) and mip.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = st_mpie;
        mstatus_val[3]     = st_mie;
        mip_val            = '0;
        mip_val[7]         = timer_irq_i;
    end

    // Read mux: the current value of the addressed CSR, or 0 with rd_mapped low for holes.
    always_comb begin
        rd_val    = '0;
        rd_mapped = 1'b1;
        case (csr_addr_i)
            ADDR_MSTATUS:   rd_val = mstatus_val;
            ADDR_MISA:      rd_val = MISA_VAL;
            ADDR_MIE:       rd_val = mie_q;
            ADDR_MTVEC:     rd_val = mtvec_q;
            ADDR_MSCRATCH:  rd_val = mscratch_q;
            ADDR_MEPC:      rd_val = mepc_q;
            ADDR_MCAUSE:    rd_val = mcause_q;
            ADDR_MTVAL:     rd_val = mtval_q;
            ADDR_MIP:       rd_val = mip_val;
            ADDR_MCYCLE:    rd_val = cycle_ext[XLEN-1:0];
            ADDR_MINSTRET:  rd_val = instret_ext[XLEN-1:0];
            ADDR_MCYCLEH:   rd_val = cycle_ext[2*XLEN-1:XLEN];
            ADDR_MINSTRETH: rd_val = instret_ext[2*XLEN-1:XLEN];
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: rd_val = '0;
            ADDR_MHARTID:   rd_val = XLEN'(HART_ID);
            default:        rd_mapped = 1'b0;
        endcase
    end

    // Classify the request and compute the read-modify-write result.
    // A trap or MRET in the same cycle discards the write but still lets the read complete cleanly.
    always_comb begin
        req_valid   = csr_req_i && (csr_op_i != 2'b00);
        wr_intent   = (csr_op_i == OP_RW) || (csr_wdata_i != '0);
        read_only   = (csr_addr_i[11:10] == 2'b11);
        event_busy  = trap_i || mret_i;
        req_illegal = req_valid && wr_intent && !event_busy && (!rd_mapped || read_only);
        do_write    = req_valid && wr_intent && !event_busy && rd_mapped && !read_only;
        case (csr_op_i)
            OP_RW:   wr_val = csr_wdata_i;
            OP_RS:   wr_val = rd_val | csr_wdata_i;
            OP_RC:   wr_val = rd_val & ~csr_wdata_i;
            default: wr_val = rd_val;
        endcase
    end

    // Counter next-state: a write to either half replaces that half and suppresses the increment.
    always_comb begin
        cycle_wr     = cycle_ext;
        instret_wr   = instret_ext;
        cycle_next   = mcycle_q + CNT_W'(1);
        instret_next = minstret_q + (inst_retire_i ? CNT_W'(1) : CNT_W'(0));
        if (do_write) begin
            case (csr_addr_i)
                ADDR_MCYCLE: begin
                    cycle_wr[XLEN-1:0] = wr_val;
                    cycle_next         = cycle_wr[CNT_W-1:0];
                end
                ADDR_MCYCLEH: begin
                    cycle_wr[2*XLEN-1:XLEN] = wr_val;
                    cycle_next              = cycle_wr[CNT_W-1:0];
                end
                ADDR_MINSTRET: begin
                    instret_wr[XLEN-1:0] = wr_val;
                    instret_next         = instret_wr[CNT_W-1:0];
                end
                ADDR_MINSTRETH: begin
                    instret_wr[2*XLEN-1:XLEN] = wr_val;
                    instret_next              = instret_wr[CNT_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Trap entry has priority over MRET, and both have priority over software CSR writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_i) begin
            mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_val_i;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (mret_i) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (do_write) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    st_mie  <= wr_val[3];
                    st_mpie <= wr_val[7];
                end
                ADDR_MIE:      mie_q      <= wr_val & MIE_MASK;
                ADDR_MTVEC:    mtvec_q    <= wr_val;
                ADDR_MSCRATCH: mscratch_q <= wr_val;
                ADDR_MEPC:     mepc_q     <= {wr_val[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_q   <= wr_val;
                ADDR_MTVAL:    mtval_q    <= wr_val;
                default: ;
            endcase
        end
    end

    // Free-running cycle counter and retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= cycle_next;
            minstret_q <= instret_next;
        end
    end

    // Registered response: a one-cycle ack per accepted request; rdata holds between acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdata_o   <= '0;
            csr_ack_o     <= 1'b0;
            csr_illegal_o <= 1'b0;
        end else begin
            csr_ack_o     <= req_valid;
            csr_illegal_o <= req_illegal;
            if (req_valid) begin
                csr_rdata_o <= rd_val;
            end
        end
    end

    // Trap target: direct base, plus a 4-byte slot per cause for vectored interrupts.
    always_comb begin
        trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00};
        if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[XLEN-1]) begin
            trap_vec_o = trap_vec_o + {trap_cause_i[XLEN-3:0], 2'b00};
        end
    end

    assign mepc_o        = mepc_q;
    assign irq_pending_o = st_mie & mie_q[7] & timer_irq_i;

endmodule

// File: tb/tb_mxrv_csr_file.sv
// Self-checking bench for mxrv_csr_file: directed scenarios plus a randomized run,
// all compared against a behavioural model of the machine-mode CSR set.
module tb_mxrv_csr_file;

    logic        clk;
    logic        rst;
    logic        csr_req_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_ack_o;
    logic        csr_illegal_o;
    logic        inst_retire_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_val_i;
    logic        mret_i;
    logic        timer_irq_i;
    logic [31:0] trap_vec_o;
    logic [31:0] mepc_o;
    logic        irq_pending_o;

    int checks;
    int failures;

    // Behavioural model state
    logic        m_mie;
    logic        m_mpie;
    logic [31:0] m_mie_reg;
    logic [31:0] m_mtvec;
    logic [31:0] m_mscratch;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mtval;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic        exp_ack;
    logic        exp_ill;
    logic [31:0] exp_rdata;

    logic [11:0] pool [22];

    mxrv_csr_file dut (
        .clk           (clk),
        .rst           (rst),
        .csr_req_i     (csr_req_i),
        .csr_op_i      (csr_op_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_ack_o     (csr_ack_o),
        .csr_illegal_o (csr_illegal_o),
        .inst_retire_i (inst_retire_i),
        .trap_i        (trap_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .trap_val_i    (trap_val_i),
        .mret_i        (mret_i),
        .timer_irq_i   (timer_irq_i),
        .trap_vec_o    (trap_vec_o),
        .mepc_o        (mepc_o),
        .irq_pending_o (irq_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return timer_irq_i ? 32'h80 : 32'h0;
            12'hB00: return m_cycle[31:0];
            12'hB02: return m_instret[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_mapped(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                         12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic logic [31:0] m_trap_vec(input logic [31:0] cause);
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
        if ((m_mtvec & 32'h3) == 32'h1 && cause[31])
            return base + 32'd4 * (cause & 32'h7FFF_FFFF);
        return base;
    endfunction

    task automatic set_idle();
        rst           = 1'b0;
        csr_req_i     = 1'b0;
        csr_op_i      = 2'b00;
        csr_addr_i    = 12'h000;
        csr_wdata_i   = 32'h0;
        inst_retire_i = 1'b0;
        trap_i        = 1'b0;
        trap_cause_i  = 32'h0;
        trap_pc_i     = 32'h0;
        trap_val_i    = 32'h0;
        mret_i        = 1'b0;
        timer_irq_i   = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_req_i   = 1'b1;
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
    endtask

    // Advance one clock: predict the effect of the held inputs, then commit after the edge.
    task automatic step();
        logic [31:0] old_v, new_v;
        logic        valid, writes, ro, evt;
        logic        n_mie, n_mpie;
        logic [31:0] n_mie_reg, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
        logic [63:0] n_cycle, n_instret;
        n_mie = m_mie; n_mpie = m_mpie; n_mie_reg = m_mie_reg; n_mtvec = m_mtvec;
        n_mscratch = m_mscratch; n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        n_cycle   = m_cycle + 64'd1;
        n_instret = m_instret + (inst_retire_i ? 64'd1 : 64'd0);
        if (rst) begin
            n_mie = 0; n_mpie = 0; n_mie_reg = 0; n_mtvec = 0; n_mscratch = 0;
            n_mepc = 0; n_mcause = 0; n_mtval = 0; n_cycle = 0; n_instret = 0;
            exp_ack = 0; exp_ill = 0; exp_rdata = 0;
        end else begin
            valid  = csr_req_i && (csr_op_i != 2'b00);
            writes = (csr_op_i == 2'b01) || (csr_wdata_i != 32'h0);
            ro     = (csr_addr_i >= 12'hC00);
            evt    = trap_i || mret_i;
            old_v  = m_read(csr_addr_i);
            case (csr_op_i)
                2'b01:   new_v = csr_wdata_i;
                2'b10:   new_v = old_v | csr_wdata_i;
                2'b11:   new_v = old_v & ~csr_wdata_i;
                default: new_v = old_v;
            endcase
            exp_ack = valid;
            exp_ill = valid && writes && !evt && (!m_mapped(csr_addr_i) || ro);
            if (valid) exp_rdata = old_v;
            if (trap_i) begin
                n_mepc = trap_pc_i & ~32'h3; n_mcause = trap_cause_i; n_mtval = trap_val_i;
                n_mpie = m_mie; n_mie = 1'b0;
            end else if (mret_i) begin
                n_mie = m_mpie; n_mpie = 1'b1;
            end else if (valid && writes && m_mapped(csr_addr_i) && !ro) begin
                case (csr_addr_i)
                    12'h300: begin n_mie = new_v[3]; n_mpie = new_v[7]; end
                    12'h304: n_mie_reg  = new_v & 32'h888;
                    12'h305: n_mtvec    = new_v;
                    12'h340: n_mscratch = new_v;
                    12'h341: n_mepc     = new_v & ~32'h3;
                    12'h342: n_mcause   = new_v;
                    12'h343: n_mtval    = new_v;
                    12'hB00: n_cycle    = {m_cycle[63:32], new_v};
                    12'hB80: n_cycle    = {new_v, m_cycle[31:0]};
                    12'hB02: n_instret  = {m_instret[63:32], new_v};
                    12'hB82: n_instret  = {new_v, m_instret[31:0]};
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_mie = n_mie; m_mpie = n_mpie; m_mie_reg = n_mie_reg; m_mtvec = n_mtvec;
        m_mscratch = n_mscratch; m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
        m_cycle = n_cycle; m_instret = n_instret;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        drive_req(2'b01, 12'h340, 32'h1111_1111);
        trap_i = 1'b1; trap_pc_i = 32'h0000_0100;
        step();
        checks += 4;
        if (csr_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", csr_ack_o); end
        if (csr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", csr_rdata_o); end
        if (csr_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal: got %b expected 0", csr_illegal_o); end
        if (mepc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_mepc: got %h expected 0", mepc_o); end
        set_idle(); rst = 1'b1; step();
        set_idle(); drive_req(2'b10, 12'hB00, 32'h0); step();
        checks += 2;
        if (csr_ack_o !== 1'b1) begin failures++; $display("[TB] FAIL first_ack: got %b expected 1", csr_ack_o); end
        if (csr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL first_mcycle: got %h expected 0", csr_rdata_o); end
        set_idle(); step();
        checks++;
        if (csr_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL ack_pulse: got %b expected 0", csr_ack_o); end
        set_idle(); drive_req(2'b10, 12'hB00, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h2) begin failures++; $display("[TB] FAIL mcycle_count: got %h expected 2", csr_rdata_o); end
    endtask

    task automatic test_mscratch();
        set_idle(); drive_req(2'b01, 12'h340, 32'hDEAD_BEEF); step();
        set_idle(); drive_req(2'b10, 12'h340, 32'h10); step();
        checks++;
        if (csr_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL rs_old: got %h expected deadbeef", csr_rdata_o); end
        set_idle(); drive_req(2'b10, 12'h340, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'hDEAD_BEFF) begin failures++; $display("[TB] FAIL rs_new: got %h expected deadbeff", csr_rdata_o); end
    endtask

    task automatic test_readonly();
        set_idle(); drive_req(2'b01, 12'hF14, 32'h5); step();
        checks += 2;
        if (csr_ack_o !== 1'b1) begin failures++; $display("[TB] FAIL ro_ack: got %b expected 1", csr_ack_o); end
        if (csr_illegal_o !== 1'b1) begin failures++; $display("[TB] FAIL ro_write_illegal: got %b expected 1", csr_illegal_o); end
        set_idle(); drive_req(2'b10, 12'hF14, 32'h0); step();
        checks += 2;
        if (csr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL hartid: got %h expected 0", csr_rdata_o); end
        if (csr_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL ro_read_legal: got %b expected 0", csr_illegal_o); end
        set_idle(); drive_req(2'b10, 12'h340, 32'h0); step();
        set_idle(); drive_req(2'b01, 12'h7C0, 32'hFFFF); step();
        checks += 2;
        if (csr_illegal_o !== 1'b1) begin failures++; $display("[TB] FAIL unmapped_illegal: got %b expected 1", csr_illegal_o); end
        if (csr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL unmapped_rdata: got %h expected 0", csr_rdata_o); end
        set_idle(); drive_req(2'b10, 12'h340, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'hDEAD_BEFF) begin failures++; $display("[TB] FAIL mscratch_kept: got %h expected deadbeff", csr_rdata_o); end
    endtask

    task automatic test_masks();
        set_idle(); drive_req(2'b01, 12'h300, 32'hFFFF_FFFF); step();
        set_idle(); drive_req(2'b10, 12'h300, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1888) begin failures++; $display("[TB] FAIL mstatus_mask: got %h expected 1888", csr_rdata_o); end
        set_idle(); drive_req(2'b01, 12'h300, 32'h0); step();
        set_idle(); drive_req(2'b01, 12'h304, 32'hFFFF_FFFF); step();
        set_idle(); drive_req(2'b10, 12'h304, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h888) begin failures++; $display("[TB] FAIL mie_mask: got %h expected 888", csr_rdata_o); end
        set_idle(); drive_req(2'b01, 12'h341, 32'h1234_5677); step();
        set_idle(); drive_req(2'b10, 12'h341, 32'h0); step();
        checks += 2;
        if (csr_rdata_o !== 32'h1234_5674) begin failures++; $display("[TB] FAIL mepc_align: got %h expected 12345674", csr_rdata_o); end
        if (mepc_o !== 32'h1234_5674) begin failures++; $display("[TB] FAIL mepc_out: got %h expected 12345674", mepc_o); end
        set_idle(); timer_irq_i = 1'b1; drive_req(2'b10, 12'h344, 32'h0); step();
        checks += 2;
        if (csr_rdata_o !== 32'h80) begin failures++; $display("[TB] FAIL mip_mtip: got %h expected 80", csr_rdata_o); end
        if (irq_pending_o !== 1'b0) begin failures++; $display("[TB] FAIL irq_masked: got %b expected 0", irq_pending_o); end
        set_idle(); drive_req(2'b10, 12'h301, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h4000_0100) begin failures++; $display("[TB] FAIL misa: got %h expected 40000100", csr_rdata_o); end
        set_idle(); timer_irq_i = 1'b1; drive_req(2'b10, 12'h300, 32'h8); step();
        checks++;
        if (irq_pending_o !== 1'b1) begin failures++; $display("[TB] FAIL irq_pending: got %b expected 1", irq_pending_o); end
    endtask

    task automatic test_trap();
        set_idle(); drive_req(2'b01, 12'h305, 32'h1001); step();
        set_idle(); drive_req(2'b01, 12'h300, 32'h8); step();
        set_idle(); trap_i = 1'b1; trap_pc_i = 32'h8000_0102; trap_cause_i = 32'h8000_0007;
        trap_val_i = 32'hABC; step();
        checks += 2;
        if (mepc_o !== 32'h8000_0100) begin failures++; $display("[TB] FAIL trap_mepc: got %h expected 80000100", mepc_o); end
        if (trap_vec_o !== 32'h101C) begin failures++; $display("[TB] FAIL trap_vec: got %h expected 101c", trap_vec_o); end
        set_idle(); drive_req(2'b10, 12'h300, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1880) begin failures++; $display("[TB] FAIL trap_mstatus: got %h expected 1880", csr_rdata_o); end
        set_idle(); drive_req(2'b10, 12'h342, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h8000_0007) begin failures++; $display("[TB] FAIL trap_mcause: got %h expected 80000007", csr_rdata_o); end
        set_idle(); mret_i = 1'b1; step();
        set_idle(); drive_req(2'b10, 12'h300, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1888) begin failures++; $display("[TB] FAIL mret_mstatus: got %h expected 1888", csr_rdata_o); end
    endtask

    task automatic test_counters();
        set_idle(); drive_req(2'b01, 12'hB00, 32'hFFFF_FFFF); step();
        set_idle(); drive_req(2'b01, 12'hB80, 32'h0); step();
        set_idle(); step();
        set_idle(); drive_req(2'b10, 12'hB80, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1) begin failures++; $display("[TB] FAIL mcycleh_wrap: got %h expected 1", csr_rdata_o); end
        set_idle(); drive_req(2'b10, 12'hB00, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1) begin failures++; $display("[TB] FAIL mcycle_after_wrap: got %h expected 1", csr_rdata_o); end
        set_idle(); inst_retire_i = 1'b1; drive_req(2'b01, 12'hB02, 32'h1234); step();
        set_idle(); drive_req(2'b10, 12'hB02, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1234) begin failures++; $display("[TB] FAIL minstret_write_wins: got %h expected 1234", csr_rdata_o); end
        set_idle(); inst_retire_i = 1'b1; drive_req(2'b01, 12'hB82, 32'h5); step();
        set_idle(); drive_req(2'b10, 12'hB82, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h5) begin failures++; $display("[TB] FAIL minstreth_write: got %h expected 5", csr_rdata_o); end
        for (int i = 0; i < 3; i++) begin
            set_idle(); inst_retire_i = 1'b1; step();
        end
        set_idle(); drive_req(2'b10, 12'hB02, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1237) begin failures++; $display("[TB] FAIL minstret_count: got %h expected 1237", csr_rdata_o); end
    endtask

    task automatic test_simultaneous();
        set_idle(); drive_req(2'b01, 12'h341, 32'h100); step();
        set_idle(); drive_req(2'b01, 12'h341, 32'hFFFF_FFF0);
        trap_i = 1'b1; trap_pc_i = 32'h4000_0006; trap_cause_i = 32'h2; step();
        checks += 4;
        if (csr_ack_o !== 1'b1) begin failures++; $display("[TB] FAIL trapwr_ack: got %b expected 1", csr_ack_o); end
        if (csr_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL trapwr_illegal: got %b expected 0", csr_illegal_o); end
        if (csr_rdata_o !== 32'h100) begin failures++; $display("[TB] FAIL trapwr_rdata: got %h expected 100", csr_rdata_o); end
        if (mepc_o !== 32'h4000_0004) begin failures++; $display("[TB] FAIL trapwr_mepc: got %h expected 40000004", mepc_o); end
        set_idle(); drive_req(2'b01, 12'h300, 32'h8); step();
        set_idle(); drive_req(2'b01, 12'hF14, 32'h5);
        trap_i = 1'b1; mret_i = 1'b1; trap_pc_i = 32'h200; step();
        checks++;
        if (csr_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL evt_ro_illegal: got %b expected 0", csr_illegal_o); end
        set_idle(); drive_req(2'b10, 12'h300, 32'h0); step();
        checks += 2;
        if (csr_rdata_o !== 32'h1880) begin failures++; $display("[TB] FAIL trap_beats_mret: got %h expected 1880", csr_rdata_o); end
        if (mepc_o !== 32'h200) begin failures++; $display("[TB] FAIL trap_mret_mepc: got %h expected 200", mepc_o); end
        set_idle(); rst = 1'b1; drive_req(2'b01, 12'h340, 32'h77); trap_i = 1'b1; trap_pc_i = 32'h300;
        trap_cause_i = 32'h8000_0003; step();
        checks += 5;
        if (csr_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL pulse_ack: got %b expected 0", csr_ack_o); end
        if (csr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL pulse_rdata: got %h expected 0", csr_rdata_o); end
        if (mepc_o !== 32'h0) begin failures++; $display("[TB] FAIL pulse_mepc: got %h expected 0", mepc_o); end
        if (trap_vec_o !== 32'h0) begin failures++; $display("[TB] FAIL pulse_trapvec: got %h expected 0", trap_vec_o); end
        if (irq_pending_o !== 1'b0) begin failures++; $display("[TB] FAIL pulse_irq: got %b expected 0", irq_pending_o); end
        set_idle(); step();
        set_idle(); drive_req(2'b10, 12'h300, 32'h0); step();
        checks++;
        if (csr_rdata_o !== 32'h1800) begin failures++; $display("[TB] FAIL pulse_mstatus: got %h expected 1800", csr_rdata_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        a = $urandom(); b = $urandom(); c = $urandom();
        set_idle(); drive_req(2'b01, 12'h340, a); step();
        checks++;
        if (csr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL b2b_rw: got %h expected 0", csr_rdata_o); end
        set_idle(); drive_req(2'b10, 12'h340, b); step();
        checks++;
        if (csr_rdata_o !== a) begin failures++; $display("[TB] FAIL b2b_rs: got %h expected %h", csr_rdata_o, a); end
        set_idle(); drive_req(2'b11, 12'h340, c); step();
        checks++;
        if (csr_rdata_o !== (a | b)) begin failures++; $display("[TB] FAIL b2b_rc: got %h expected %h", csr_rdata_o, a | b); end
        set_idle(); drive_req(2'b10, 12'h340, 32'h0); step();
        checks++;
        if (csr_rdata_o !== ((a | b) & ~c)) begin failures++; $display("[TB] FAIL b2b_final: got %h expected %h", csr_rdata_o, (a | b) & ~c); end
    endtask

    task automatic test_random();
        logic [31:0] e_vec;
        logic        e_irq;
        for (int i = 0; i < 400; i++) begin
            set_idle();
            rst           = ($urandom_range(0, 59) == 0);
            csr_req_i     = ($urandom_range(0, 4) != 0);
            csr_op_i      = 2'($urandom_range(0, 3));
            csr_addr_i    = pool[$urandom_range(0, 21)];
            csr_wdata_i   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            inst_retire_i = 1'($urandom_range(0, 1));
            trap_i        = ($urandom_range(0, 15) == 0);
            mret_i        = ($urandom_range(0, 15) == 0);
            trap_cause_i  = $urandom();
            trap_pc_i     = $urandom();
            trap_val_i    = $urandom();
            timer_irq_i   = 1'($urandom_range(0, 1));
            step();
            e_vec = m_trap_vec(trap_cause_i);
            e_irq = m_mie & m_mie_reg[7] & timer_irq_i;
            checks += 6;
            if (csr_ack_o !== exp_ack) begin failures++; $display("[TB] FAIL rnd_ack[%0d]: got %b expected %b", i, csr_ack_o, exp_ack); end
            if (csr_rdata_o !== exp_rdata) begin failures++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", i, csr_rdata_o, exp_rdata); end
            if (csr_illegal_o !== exp_ill) begin failures++; $display("[TB] FAIL rnd_illegal[%0d]: got %b expected %b", i, csr_illegal_o, exp_ill); end
            if (mepc_o !== m_mepc) begin failures++; $display("[TB] FAIL rnd_mepc[%0d]: got %h expected %h", i, mepc_o, m_mepc); end
            if (trap_vec_o !== e_vec) begin failures++; $display("[TB] FAIL rnd_trapvec[%0d]: got %h expected %h", i, trap_vec_o, e_vec); end
            if (irq_pending_o !== e_irq) begin failures++; $display("[TB] FAIL rnd_irq[%0d]: got %b expected %b", i, irq_pending_o, e_irq); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13,
                 12'hF14, 12'h7C0, 12'hC00, 12'hF15, 12'h345, 12'hB01};
        set_idle();
        test_reset();
        test_mscratch();
        test_readonly();
        test_masks();
        test_trap();
        test_counters();
        test_simultaneous();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mxrv_csr_file.md
MXRV_CSR_FILE -- requirements
Module: mxrv_csr_file

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, register width.
- CNT_W, 64, cycle/instret counter width; legal range XLEN..2*XLEN.
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 32'h4000_0100, value returned by misa (RV32I).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, synchronous reset, active-high.
- csr_req_i, in, 1, CSR access request.
- csr_op_i, in, 2, 01=RW, 10=RS, 11=RC; 00 is ignored.
- csr_addr_i, in, 12, CSR address.
- csr_wdata_i, in, XLEN, write operand.
- csr_rdata_o, out, XLEN, registered old value.
- csr_ack_o, out, 1, access complete.
- csr_illegal_o, out, 1, access faulted; qualified by csr_ack_o.
- inst_retire_i, in, 1, one instruction retired.
- trap_i, in, 1, trap entry strobe.
- trap_cause_i, in, XLEN, cause value for the trap.
- trap_pc_i, in, XLEN, faulting PC.
- trap_val_i, in, XLEN, trap value.
- mret_i, in, 1, MRET strobe.
- timer_irq_i, in, 1, machine timer level.
- trap_vec_o, out, XLEN, trap target PC (combinational).
- mepc_o, out, XLEN, current mepc (combinational).
- irq_pending_o, out, 1, enabled timer interrupt pending.

Function
REQ-003 Address map: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14.
REQ-004 Request with op!=00 is sampled on the clk edge; csr_ack_o is a 1-cycle pulse on the next cycle; no back-pressure; back-to-back requests are accepted every cycle.
REQ-005 csr_rdata_o carries the pre-write value of the addressed CSR; it holds its value while there is no ack.
REQ-006 New value is computed as: RW=wdata; RS=old|wdata; RC=old&~wdata. RS/RC with wdata==0 performs no write.
REQ-007 A write to addr[11:10]==2'b11 (read-only space) or to any unmapped address sets csr_illegal_o, leaves state unchanged, and returns rdata 0 for unmapped addresses; RS/RC with wdata==0 to a read-only address is legal.
REQ-008 Write masks:
- mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11.
- mie: only bits 3, 7, 11 are writable.
- mepc: bits [1:0] read 0.
- mtvec: all bits are writable.
- mip: MTIP[7] mirrors timer_irq_i; all other bits read 0.
- misa, mvendorid, marchid, mimpid, mhartid: constants (MISA_VAL, 0, 0, 0, HART_ID).
REQ-009 mcycle increments by 1 every cycle and wraps modulo 2^CNT_W.
REQ-010 minstret increments on inst_retire_i and wraps modulo 2^CNT_W.
REQ-011 The h-registers expose counter bits [CNT_W-1:XLEN] zero-extended; they read 0 when CNT_W==XLEN.
REQ-012 A CSR write to a counter half replaces that half; in that cycle the write wins over the increment for the whole counter.
REQ-013 trap_i updates, at the next edge:
- mepc <= trap_pc_i with bits [1:0] cleared;
- mcause <= trap_cause_i;
- mtval <= trap_val_i;
- MPIE <= MIE;
- MIE <= 0.
REQ-014 mret_i updates MIE <= MPIE and MPIE <= 1.
REQ-015 Simultaneous events:
- trap_i and mret_i together: trap wins, mret is ignored.
- trap_i or mret_i with a CSR write: the CSR write is discarded, ack is still given with old rdata, csr_illegal_o=0.
REQ-016 trap_vec_o = {mtvec[XLEN-1:2],2'b00}. When mtvec[1:0]==01 and trap_cause_i[XLEN-1]==1 (vectored interrupt), add 4*trap_cause_i[XLEN-2:0].
REQ-017 irq_pending_o = mstatus.MIE & mie[7] & timer_irq_i.

Reset
REQ-018 rst=1 at a clk edge clears all writable CSRs, both counters, csr_rdata_o, csr_ack_o and csr_illegal_o to 0.
REQ-019 A request or trap presented in a reset cycle is dropped and produces no ack.
REQ-020 The first increment of either counter occurs at the first edge with rst=0.

Verification
REQ-021 RW 0x340 with 0xDEADBEEF, then RS 0x340 with 0x10 -> second ack returns rdata 0xDEADBEEF; mscratch becomes 0xDEADBEFF.
REQ-022 RW 0xF14 with 0x5 -> ack with csr_illegal_o=1; a subsequent RS 0xF14 with wdata 0 returns HART_ID with illegal=0.
REQ-023 Set MIE=1, then trap_i with pc 0x8000_0102 and cause 0x8000_0007 while mtvec=0x1001 -> mepc=0x8000_0100, MPIE=1, MIE=0, trap_vec_o=0x101C; mret -> MIE=1.
REQ-024 Write mcycle=0xFFFF_FFFF and mcycleh=0 in consecutive cycles -> after the wrap, mcycleh reads 1 and mcycle counts up from 0; inst_retire_i held during the write cycle -> the write value wins.
REQ-025 Assert trap_i and a RW to 0x341 in the same cycle, with rst pulsed mid-sequence -> mepc holds the trap PC, ack is given; after reset all outputs read 0.
